serial_branch_comp: RTL and testbench



---
 rtl/serial_branch_comp_if.sv | 11 +
 rtl/serial_branch_comp.sv | 69 ++++++
 tb/tb_serial_branch_comp.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_branch_comp_if.sv
// serial_branch_comp_if: operand/result valid-ready bundle for serial_branch_comp
interface serial_branch_comp_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready;
  logic gt, lt, eq, taken, illegal;
  logic [WIDTH-1:0] a, b;
  logic [2:0] funct3;
  modport master(output in_valid, a, b, funct3, out_ready,
                 input in_ready, out_valid, gt, lt, eq, taken, illegal);
  modport slave(input in_valid, a, b, funct3, out_ready,
                output in_ready, out_valid, gt, lt, eq, taken, illegal);
endinterface

// File: rtl/serial_branch_comp.sv
// serial_branch_comp: digit-serial MSB-first branch comparator; SERIAL_BRANCH_COMP_EARLY_EXIT_EN stops at the first differing digit
module serial_branch_comp #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic reset,
  serial_branch_comp_if.slave bus
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [2:0] f3;
  logic decided, gt_r, lt_r, hit, last, sgn;
  logic [CW-1:0] count;
  logic [DIGIT-1:0] da, db;
  assign da = sa[WIDTH-1 -: DIGIT];
  assign db = sb[WIDTH-1 -: DIGIT];
  assign hit = !decided && da != db;
  assign sgn = bus.funct3[2:1] == 2'b10;
`ifdef SERIAL_BRANCH_COMP_EARLY_EXIT_EN
  assign last = count == '0 || hit;
`else
  assign last = count == '0;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (bus.in_valid ? SCAN : IDLE) :
          state == SCAN ? (last ? DONE : SCAN) :
          (bus.out_ready ? IDLE : DONE);
  // Inverting the MSB turns a signed compare into an unsigned one
  always_ff @(posedge clk)
    if (reset) begin
      count <= '0;
      decided <= 1'b0;
      gt_r <= 1'b0;
      lt_r <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      sa <= {bus.a[WIDTH-1] ^ sgn, bus.a[WIDTH-2:0]};
      sb <= {bus.b[WIDTH-1] ^ sgn, bus.b[WIDTH-2:0]};
      f3 <= bus.funct3;
      decided <= 1'b0;
      gt_r <= 1'b0;
      lt_r <= 1'b0;
      count <= CW'(N - 1);
    end else if (state == SCAN) begin
      if (hit) begin
        gt_r <= da > db;
        lt_r <= da < db;
        decided <= 1'b1;
      end
      sa <= sa << DIGIT;
      sb <= sb << DIGIT;
      count <= count - 1'b1;
    end
  always_comb begin
    bus.in_ready = state == IDLE && !reset;
    bus.out_valid = state == DONE;
    bus.gt = bus.out_valid && gt_r;
    bus.lt = bus.out_valid && lt_r;
    bus.eq = bus.out_valid && !decided;
    bus.illegal = bus.out_valid && f3[2:1] == 2'b01;
    bus.taken = bus.out_valid && !bus.illegal && (f3[2] ? (lt_r ^ f3[0]) : (!decided ^ f3[0]));
  end
endmodule

// File: tb/tb_serial_branch_comp.sv
// tb_serial_branch_comp: directed vectors checked against an arithmetic branch model
module tb_serial_branch_comp;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int pass_cnt = 0;
  int total = 0;
  logic e_gt, e_lt, e_eq, e_taken, e_ill;
  int e_lat;
  always #5 clk = ~clk;
  serial_branch_comp_if #(.WIDTH(32)) bus();
  serial_branch_comp #(.WIDTH(32), .DIGIT(4)) dut(.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    logic [31:0] x;
    int p;
    int k;
    e_eq = a == b;
    e_gt = f3[2:1] == 2'b10 ? ($signed(a) > $signed(b)) : (a > b);
    e_lt = !e_gt && !e_eq;
    e_ill = f3 == 3'b010 || f3 == 3'b011;
    case (f3)
      3'b000: e_taken = e_eq;
      3'b001: e_taken = !e_eq;
      3'b100, 3'b110: e_taken = e_lt;
      3'b101, 3'b111: e_taken = !e_lt;
      default: e_taken = 1'b0;
    endcase
    x = a ^ b;
    p = -1;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    k = p < 0 ? N : (31 - p) / 4 + 1;
`ifdef SERIAL_BRANCH_COMP_EARLY_EXIT_EN
    e_lat = k;
`else
    e_lat = N;
`endif
  endtask

  always @(negedge clk)
    if (bus.out_valid) begin
      chk("gt", bus.gt, e_gt);
      chk("lt", bus.lt, e_lt);
      chk("eq", bus.eq, e_eq);
      chk("taken", bus.taken, e_taken);
      chk("illegal", bus.illegal, e_ill);
      chk("onehot", $countones({bus.gt, bus.lt, bus.eq}), 1);
    end else
      chk("idle_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 0);

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("in_ready_wait", 0, 1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.funct3 = f3;
    @(posedge clk);
    model(a, b, f3);
    #1 bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.funct3 = 3'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!bus.out_valid && lat < 40);
    chk("latency", lat, e_lat);
  endtask

  task automatic pop();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("pop_out_valid", bus.out_valid, 0);
    chk("pop_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    int lat;
    int seen;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.funct3 = '0;
    repeat (2) @(posedge clk);
    #1 chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    @(negedge clk) reset = 1'b0;
    #1 chk("in_ready_after_rst", bus.in_ready, 1);

    issue(32'h0056eecd, 32'h0056eecd, 3'b000);
    wait_result(lat);
    chk("beq_lat", lat, 8);
    chk("beq_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b00110);
    pop();

    issue(32'h46f63068, 32'hdade4fde, 3'b100);
    wait_result(lat);
    chk("blt_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b10000);
    pop();

    issue(32'h46f63068, 32'hdade4fde, 3'b110);
    wait_result(lat);
    chk("bltu_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b01010);
    pop();

    issue(32'h0358d819, 32'h02f20715, 3'b111);
    wait_result(lat);
`ifdef SERIAL_BRANCH_COMP_EARLY_EXIT_EN
    chk("bgeu_lat", lat, 2);
`else
    chk("bgeu_lat", lat, 8);
`endif
    chk("bgeu_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b10010);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 32'h13903038;
    bus.b = 32'h38393973;
    bus.funct3 = 3'b011;
    repeat (5) begin
      @(posedge clk);
      #1 chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_hold", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b10010);
    end
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    @(posedge clk);
    model(32'h13903038, 32'h38393973, 3'b011);
    #1 bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    chk("bp_accepted", bus.in_ready, 0);
    wait_result(lat);
    chk("illegal_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b01001);
    pop();

    issue(32'h12345678, 32'h12345678, 3'b000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 chk("abort_in_ready_in_rst", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    @(negedge clk) reset = 1'b0;
    #1 chk("abort_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    issue(32'h80000000, 32'h7fffffff, 3'b101);
    wait_result(lat);
    chk("bge_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b01000);
    pop();

    issue(32'h80000000, 32'h7fffffff, 3'b111);
    wait_result(lat);
    chk("bgeu_msb_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b10010);
    pop();

    issue(32'h00000010, 32'h00000011, 3'b001);
    wait_result(lat);
    chk("bne_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b01010);
    pop();

    issue(32'hffffffff, 32'h00000001, 3'b100);
    wait_result(lat);
    chk("blt_neg_flags", {bus.gt, bus.lt, bus.eq, bus.taken, bus.illegal}, 5'b01010);
    pop();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
